// File: rtl/psum_accum_array.sv
// ============================================================================
// Module      : psum_accum_array
// Description : N_CH-lane partial-sum accumulator over a configurable number
//               of beats, with optional saturation and a single-entry output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module psum_accum_array #(
    parameter int DATA_WIDTH = 32,
    parameter int N_CH       = 4,
    parameter int CNT_WIDTH  = 8,
    parameter int SATURATE   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CNT_WIDTH-1:0]       cfg_acc_len,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_CH*DATA_WIDTH-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N_CH*DATA_WIDTH-1:0] out_data,
    output logic [N_CH-1:0]            out_sat,
    output logic                       busy
);

    localparam logic [CNT_WIDTH-1:0] c_one = CNT_WIDTH'(1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [CNT_WIDTH-1:0]        r_cnt;
    logic [CNT_WIDTH-1:0]        w_cnt_nxt;
    logic [CNT_WIDTH-1:0]        r_len;
    logic [CNT_WIDTH-1:0]        w_cfg_len;
    logic                        w_first;
    logic                        w_last;
    logic                        w_fire;

    logic [N_CH*DATA_WIDTH-1:0]  r_acc;
    logic [N_CH-1:0]             r_sat;
    logic [N_CH*DATA_WIDTH-1:0]  w_res;
    logic [N_CH-1:0]             w_flag;
    logic                        r_out_valid;
    logic [N_CH*DATA_WIDTH-1:0]  r_out_data;
    logic [N_CH-1:0]             r_out_sat;

    assign w_cfg_len = (cfg_acc_len == '0) ? c_one : cfg_acc_len;
    assign w_first   = (r_state == IDLE);
    assign w_last    = w_first ? (w_cfg_len == c_one) : (r_cnt == (r_len - c_one));

    // A last beat may only enter when the output register is free or draining.
    assign in_ready  = !rst && !(w_last && r_out_valid && !out_ready);
    assign w_fire    = in_valid && in_ready;

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign busy      = (r_state == ACC);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_fire) begin
            if (w_last) begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end else if (w_first) begin
                w_state_nxt = ACC;
                w_cnt_nxt   = c_one;
            end else begin
                w_cnt_nxt   = r_cnt + c_one;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_len   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_fire && w_first) begin
                r_len <= w_cfg_len;
            end
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_lane
        logic [DATA_WIDTH-1:0] w_base;
        logic [DATA_WIDTH-1:0] w_in;
        logic [DATA_WIDTH-1:0] w_sum;
        logic                  w_ovf;

        // The first beat starts from zero, so no clear cycle is needed between sums.
        assign w_base = w_first ? '0 : r_acc[c*DATA_WIDTH +: DATA_WIDTH];
        assign w_in   = in_data[c*DATA_WIDTH +: DATA_WIDTH];
        assign w_sum  = w_base + w_in;
        assign w_ovf  = (w_base[DATA_WIDTH-1] == w_in[DATA_WIDTH-1]) &&
                        (w_sum[DATA_WIDTH-1] != w_base[DATA_WIDTH-1]);
        assign w_flag[c] = (w_first ? 1'b0 : r_sat[c]) | w_ovf;

        if (SATURATE != 0) begin : g_sat
            assign w_res[c*DATA_WIDTH +: DATA_WIDTH] =
                !w_ovf ? w_sum :
                (w_base[DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                      : {1'b0, {(DATA_WIDTH-1){1'b1}}});
        end else begin : g_wrap
            assign w_res[c*DATA_WIDTH +: DATA_WIDTH] = w_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_sat       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= '0;
        end else begin
            if (w_fire) begin
                r_acc <= w_res;
                r_sat <= w_flag;
            end
            if (w_fire && w_last) begin
                r_out_data  <= w_res;
                r_out_sat   <= w_flag;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_psum_accum_array.sv
// ============================================================================
// Module      : tb_psum_accum_array
// Description : Scoreboard bench for psum_accum_array (32-bit saturating and
//               8-bit wrapping instances driven by identical control).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_psum_accum_array;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int CW = 8;
    localparam longint MAX32 = 64'sd2147483647;
    localparam longint MIN32 = -64'sd2147483648;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [CW-1:0]  cfg = '0;
    logic           in_valid = 1'b0;
    logic [N*W-1:0] in_data = '0;
    logic           out_ready = 1'b0;
    logic           in_ready, out_valid, busy;
    logic [N*W-1:0] out_data;
    logic [N-1:0]   out_sat;
    logic [N*8-1:0] in8;
    logic           in_ready8, out_valid8, busy8;
    logic [N*8-1:0] out_data8;
    logic [N-1:0]   out_sat8;

    always #5 clk = ~clk;

    assign in8 = {in_data[103:96], in_data[71:64], in_data[39:32], in_data[7:0]};

    psum_accum_array #(.DATA_WIDTH(W), .N_CH(N), .CNT_WIDTH(CW), .SATURATE(1)) dut (
        .clk(clk), .rst(rst), .cfg_acc_len(cfg), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .busy(busy)
    );

    psum_accum_array #(.DATA_WIDTH(8), .N_CH(N), .CNT_WIDTH(CW), .SATURATE(0)) dut8 (
        .clk(clk), .rst(rst), .cfg_acc_len(cfg), .in_valid(in_valid), .in_ready(in_ready8),
        .in_data(in8), .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8),
        .out_sat(out_sat8), .busy(busy8)
    );

    typedef struct packed {
        logic [N*W-1:0] d32;
        logic [N-1:0]   s32;
        logic [N*8-1:0] d8;
        logic [N-1:0]   s8;
    } exp_t;

    exp_t   q[$];
    longint m_acc32[N];
    longint m_acc8[N];
    logic [N-1:0] m_f32, m_f8;
    int     m_len = 1;
    int     m_cnt = 0;
    bit     m_busy = 1'b0;
    int     n_cmp = 0;
    int     n_err = 0;

    task automatic check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N*W-1:0] pack(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c, input logic [31:0] d);
        return {d, c, b, a};
    endfunction

    // Reference: exact integer sums per beat, clamped (32-bit) or wrapped (8-bit).
    function automatic void model_accept(input logic [N*W-1:0] d, input logic [CW-1:0] cf);
        exp_t e;
        if (!m_busy) begin
            m_len = (cf == 0) ? 1 : int'(cf);
            m_cnt = 0;
            m_f32 = '0;
            m_f8  = '0;
            for (int c = 0; c < N; c++) begin
                m_acc32[c] = 0;
                m_acc8[c]  = 0;
            end
        end
        for (int c = 0; c < N; c++) begin
            logic [31:0] lane;
            logic [7:0]  b8, t8;
            longint      s;
            lane = d[c*W +: W];
            s = m_acc32[c] + longint'($signed(lane));
            if (s > MAX32) begin s = MAX32; m_f32[c] = 1'b1; end
            if (s < MIN32) begin s = MIN32; m_f32[c] = 1'b1; end
            m_acc32[c] = s;
            b8 = lane[7:0];
            s = m_acc8[c] + longint'($signed(b8));
            if (s > 127 || s < -128) m_f8[c] = 1'b1;
            t8 = s[7:0];
            m_acc8[c] = longint'($signed(t8));
        end
        m_cnt++;
        if (m_cnt == m_len) begin
            for (int c = 0; c < N; c++) begin
                logic [63:0] v32, v8;
                v32 = m_acc32[c];
                v8  = m_acc8[c];
                e.d32[c*W +: W] = v32[31:0];
                e.d8[c*8 +: 8]  = v8[7:0];
            end
            e.s32 = m_f32;
            e.s8  = m_f8;
            q.push_back(e);
            m_busy = 1'b0;
        end else begin
            m_busy = 1'b1;
        end
    endfunction

    // Monitor: handshake expectations and scoreboard pop on every output transfer.
    always @(negedge clk) begin
        if (rst) begin
            check("in_ready_rst", {in_ready8, in_ready}, '0);
        end else begin
            int  cf_eff;
            bit  exp_nl, hold;
            exp_t e;
            cf_eff = (cfg == 0) ? 1 : int'(cfg);
            exp_nl = m_busy ? (m_cnt + 1 == m_len) : (cf_eff == 1);
            hold   = (q.size() != 0);
            check("out_valid", {out_valid8, out_valid}, {2{hold}});
            check("in_ready", {in_ready8, in_ready}, {2{!(exp_nl && hold && !out_ready)}});
            check("busy", {busy8, busy}, {2{m_busy}});
            if (hold && out_ready) begin
                e = q.pop_front();
                check("data32", out_data, e.d32);
                check("sat32", out_sat, e.s32);
                check("data8", out_data8, e.d8);
                check("sat8", out_sat8, e.s8);
            end
        end
    end

    // Called at posedge+1; returns at the following posedge+1.
    task automatic step(input bit v, input logic [N*W-1:0] d, input logic [CW-1:0] cf, input bit ordy);
        bit fire;
        in_valid  = v;
        in_data   = d;
        cfg       = cf;
        out_ready = ordy;
        @(negedge clk);
        #1;
        fire = in_valid && in_ready;
        @(posedge clk);
        if (fire) model_accept(d, cf);
        #1;
    endtask

    task automatic reset_dut();
        rst      = 1'b1;
        in_valid = 1'b0;
        q.delete();
        m_busy = 1'b0;
        m_cnt  = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("rst_state", {out_data, out_sat, out_valid, busy}, '0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_lane();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 20)) - 32'd10;
            1:       return 32'($urandom());
            2:       return 32'h7FFF_FFF0 + 32'($urandom_range(0, 15));
            default: return 32'h8000_0010 - 32'($urandom_range(0, 16));
        endcase
    endfunction

    initial begin
        int pct;
        @(posedge clk);
        #1;
        reset_dut();

        // Three-beat accumulation with mixed signs.
        step(1, pack(1, 2, 3, 4), 3, 1);
        step(1, pack(10, 20, 30, 40), 3, 1);
        step(1, pack(-5, -5, -5, -5), 3, 1);
        check("plan_sum", out_data, pack(6, 17, 28, 39));
        step(0, '0, 3, 1);

        // Single-beat accumulations back to back.
        step(1, pack(5, 5, 5, 5), 1, 1);
        step(1, pack(6, 6, 6, 6), 0, 1);
        step(1, pack(7, 7, 7, 7), 1, 1);
        step(0, '0, 1, 1);

        // Saturation (32-bit) and wrap (8-bit) boundaries.
        step(1, pack(100, -100, 32'h7FFF_FFF0, 32'h8000_0010), 2, 1);
        step(1, pack(100, -100, 32'h7FFF_FFF0, 32'h8000_0010), 2, 1);
        check("sat_data32", out_data, pack(200, -200, 32'h7FFF_FFFF, 32'h8000_0000));
        check("sat_flag32", out_sat, 4'b1100);
        check("wrap_data8", out_data8, 32'h20E0_38C8);
        check("wrap_flag8", out_sat8, 4'b0011);
        step(0, '0, 2, 1);

        // Output stall: first beat accepted, last beat held, then pop and load together.
        step(1, pack(1, 1, 1, 1), 2, 1);
        step(1, pack(2, 2, 2, 2), 2, 0);
        step(1, pack(3, 3, 3, 3), 2, 0);
        repeat (3) step(1, pack(4, 4, 4, 4), 2, 0);
        check("stall_hold", out_data, pack(3, 3, 3, 3));
        step(1, pack(4, 4, 4, 4), 2, 1);
        check("no_bubble", {out_valid, out_data}, {1'b1, pack(7, 7, 7, 7)});
        step(0, '0, 2, 1);

        // Reset mid-accumulation, then a clean accumulation.
        step(1, pack(9, 9, 9, 9), 4, 1);
        step(1, pack(9, 9, 9, 9), 4, 1);
        reset_dut();
        repeat (4) step(1, pack(1, 1, 1, 1), 4, 1);
        check("post_rst_sum", out_data, pack(4, 4, 4, 4));
        step(0, '0, 4, 1);

        // Randomized traffic with varying consumer back-pressure.
        for (int ph = 0; ph < 4; ph++) begin
            pct = (ph == 0) ? 100 : (ph == 1) ? 60 : (ph == 2) ? 20 : 90;
            for (int i = 0; i < 800; i++) begin
                step($urandom_range(0, 3) != 0,
                     pack(rand_lane(), rand_lane(), rand_lane(), rand_lane()),
                     CW'($urandom_range(0, 5)),
                     $urandom_range(0, 99) < pct);
            end
        end

        repeat (10) step(0, '0, 1, 1);
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d results outstanding expected 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/psum_accum_array.md
Name: psum_accum_array

Overview:
- Multi-channel partial-sum accumulator. Generalised, registered successor to the single combinational psum adder.
- Sums N_CH parallel psum lanes over a configurable number of input beats, with optional per-lane saturation.
- Presents each finished sum in a single-entry output register with valid/ready on both sides.
- Sits between the PE array psum outputs and the output/activation stage of the diff core.

Parameters:
- DATA_WIDTH, 32, psum lane width in bits; two's-complement signed.
- N_CH, 4, number of parallel lanes.
- CNT_WIDTH, 8, width of the beat-count config and internal counter.
- SATURATE, 1, 1 = clamp to signed range on overflow; 0 = wrap modulo 2^DATA_WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- cfg_acc_len  in  CNT_WIDTH  beats per accumulation; 0 treated as 1; sampled on the first beat of each accumulation.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  N_CH*DATA_WIDTH  lane c at bits [c*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  finished sum held in the output register.
- out_ready  in  1  consumer accepts the result.
- out_data  out  N_CH*DATA_WIDTH  finished sums, same lane packing as in_data.
- out_sat  out  N_CH  per-lane sticky flag: saturation or overflow occurred during this accumulation.
- busy  out  1  accumulation in progress (state ACC).

Behaviour:
- Reset (synchronous, active-high):
  - State = IDLE; beat counter = 0; accumulators = 0.
  - out_valid = 0, out_data = 0, out_sat = 0, busy = 0.
  - in_ready = 0 while rst is high; from the first cycle after reset in_ready = 1.
  - Reset mid-accumulation discards the partial sum and any unconsumed result.
- States:
  - IDLE: the next accepted beat is the first beat.
    - It latches len = max(cfg_acc_len, 1) and starts acc[c] from 0.
    - If len = 1 it is also the last beat and the state stays IDLE.
    - Otherwise the state goes to ACC with cnt = 1.
  - ACC: each accepted beat does acc[c] += in[c] and cnt += 1.
    - The beat with cnt == len-1 is the last beat: state goes to IDLE and cnt goes to 0.
- Arithmetic:
  - Full-width signed add per lane.
  - Overflow is detected when both operands have the same sign and the result's sign differs.
  - SATURATE = 1: the result clamps to 2^(W-1)-1 or -2^(W-1), and later beats add onto the clamped value.
  - SATURATE = 0: the result wraps.
  - Either mode: the lane's sticky flag sets on overflow and clears at the first beat of the next accumulation.
- Completion:
  - Accepting the last beat at edge k loads out_data = final sums and out_sat = final flags, and sets out_valid = 1 after edge k.
  - Latency is 1 cycle from last-beat acceptance to out_valid.
  - Results are never dropped or overwritten while unconsumed.
- Handshake:
  - in_ready = !(next beat is last && out_valid && !out_ready).
  - Non-last beats are accepted while a result is stalled on the output.
  - in_ready does not depend on in_valid.
  - out_data and out_sat stay stable while out_valid && !out_ready.
  - out_valid falls after an edge with out_ready = 1, unless a new last beat loads in the same cycle.
- Simultaneous events:
  - A last beat accepted while the output is popped loads the new result; out_valid stays 1, with no bubble.
  - in_valid low mid-accumulation holds state indefinitely.
  - cfg_acc_len changes while busy are ignored until the next first beat.
- busy = (state == ACC).

Test Plan:
- DATA_WIDTH=32, N_CH=4, cfg_acc_len=3, out_ready=1; beats {1,2,3,4}, {10,20,30,40}, {-5,-5,-5,-5} -> one cycle after the 3rd beat: out_valid=1, out_data={6,17,28,39}, out_sat=0.
- DATA_WIDTH=8, SATURATE=1, len=2, lane0 beats 100 then 100, lane1 -100 then -100 -> lane0=127, lane1=-128, out_sat=4'b0011. With SATURATE=0 the same stimulus gives lane0=-56, lane1=56, out_sat=4'b0011.
- len=1 with back-to-back beats 5, 6, 7, out_ready=1 -> out_data 5, 6, 7 on consecutive cycles; in_ready stays 1.
- len=2, out_ready=0 after the first result -> the next first beat is accepted; in_ready=0 on the last beat until out_ready=1. The held result stays stable; the second result appears the cycle after its last beat is accepted.
- Pop and last beat in the same cycle -> out_valid stays 1 and out_data switches to the new sum.
- Assert rst after 2 of 4 beats -> out_valid=0, busy=0; the next accumulation of {1,1,1,1} × 4 beats gives out_data={4,4,4,4}, with no residue from before reset.
